// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory load/store path.
package mem_pkg;

  localparam int unsigned TIMEOUT_CYC_DEF = 16;
  localparam int unsigned CNT_W_DEF       = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

endpackage

// File: rtl/mem_load_extract.sv
// Selects the addressed byte/halfword from a memory word and extends it to 32 bits.
module mem_load_extract
  import mem_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  addr_lo,
  input  logic        unsigned_ld,
  input  logic [31:0] word,
  output logic [31:0] result_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by sign or zero extension.
  always_comb begin
    byte_sel = word[7:0];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    result_c = word;
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    case (size)
      SZ_BYTE: result_c = {{24{~unsigned_ld & byte_sel[7]}}, byte_sel};
      SZ_HALF: result_c = {{16{~unsigned_ld & half_sel[15]}}, half_sel};
      default: result_c = word;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// Load unit: alignment check, word read with timeout, extraction, WB handshake.
module mem_load_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic        full,
  input  logic        half,
  input  logic        byte_ld,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  output logic        dm_req,
  output logic [29:0] dm_addr,
  input  logic [31:0] dm_rdata,
  input  logic        dm_rvalid,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  input  logic        rd_ready,
  output logic        stall,
  output logic        adel,
  output logic        bus_err,
  output logic [31:0] badvaddr
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  size_t            size_q;
  logic [31:0]      addr_q;
  logic             uns_q;

  size_t            req_size_c;
  logic             req_legal_c;
  logic             req_misal_c;
  logic [31:0]      ext_c;

  // Decode requested size with full > half > byte priority and check alignment.
  always_comb begin
    req_legal_c = full | half | byte_ld;
    req_size_c  = SZ_BYTE;
    req_misal_c = 1'b0;
    if (full) begin
      req_size_c  = SZ_WORD;
      req_misal_c = (addr[1:0] != 2'b00);
    end else if (half) begin
      req_size_c  = SZ_HALF;
      req_misal_c = addr[0];
    end
  end

  mem_load_extract u_extract (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .unsigned_ld (uns_q),
    .word        (dm_rdata),
    .result_c    (ext_c)
  );

  // Load FSM with registered outputs; error flags are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      uns_q    <= 1'b0;
      ld_ready <= 1'b1;
      dm_req   <= 1'b0;
      dm_addr  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      stall    <= 1'b0;
      adel     <= 1'b0;
      bus_err  <= 1'b0;
      badvaddr <= '0;
    end else begin
      adel    <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_valid && req_legal_c) begin
            addr_q   <= addr;
            size_q   <= req_size_c;
            uns_q    <= unsigned_ld;
            cnt      <= '0;
            ld_ready <= 1'b0;
            if (req_misal_c) begin
              state    <= ERR;
              adel     <= 1'b1;
              badvaddr <= addr;
            end else begin
              state   <= REQ;
              dm_req  <= 1'b1;
              dm_addr <= addr[31:2];
              stall   <= 1'b1;
            end
          end
        end
        REQ: begin
          if (dm_rvalid) begin
            state    <= RESP;
            dm_req   <= 1'b0;
            rd_valid <= 1'b1;
            rd_data  <= ext_c;
            cnt      <= '0;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state    <= ERR;
            dm_req   <= 1'b0;
            stall    <= 1'b0;
            bus_err  <= 1'b1;
            badvaddr <= addr_q;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rd_ready) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            stall    <= 1'b0;
            ld_ready <= 1'b1;
          end
        end
        ERR: begin
          state    <= IDLE;
          ld_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          dm_req   <= 1'b0;
          rd_valid <= 1'b0;
          stall    <= 1'b0;
          ld_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
// Self-checking bench for mem_load_unit against a behavioural extraction/timing model.
module tb_mem_load_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, ld_ready, full, half, byte_ld, unsigned_ld;
  logic [31:0] addr;
  logic        dm_req;
  logic [29:0] dm_addr;
  logic [31:0] dm_rdata;
  logic        dm_rvalid;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        stall, adel, bus_err;
  logic [31:0] badvaddr;

  int tests = 0;
  int fails = 0;

  // Observations captured by the transaction driver.
  logic [29:0] obs_addr;
  logic [31:0] obs_data;
  logic        obs_valid, obs_stall_ok, obs_hold_ok, obs_err;
  logic [2:0]  obs_after;
  int          obs_lat;

  mem_load_unit dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .full(full), .half(half), .byte_ld(byte_ld), .unsigned_ld(unsigned_ld),
    .addr(addr), .dm_req(dm_req), .dm_addr(dm_addr), .dm_rdata(dm_rdata),
    .dm_rvalid(dm_rvalid), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .stall(stall), .adel(adel), .bus_err(bus_err),
    .badvaddr(badvaddr)
  );

  always #5 clk = ~clk;

  // Reference: shift the addressed lane down, mask to size, then extend.
  function automatic logic [31:0] model(input int nbytes, input logic [1:0] lo,
                                        input logic u, input logic [31:0] w);
    logic [31:0] v, mask;
    int off, bits;
    if (nbytes == 4) return w;
    off  = (nbytes == 2) ? int'(lo[1]) * 2 : int'(lo);
    bits = nbytes * 8;
    mask = (32'h1 << bits) - 32'h1;
    v    = (w >> (8 * off)) & mask;
    if (!u && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic issue(input logic f, input logic h, input logic b, input logic u,
                       input logic [31:0] a);
    ld_valid = 1'b1; full = f; half = h; byte_ld = b; unsigned_ld = u; addr = a;
    @(posedge clk); #1;
    ld_valid = 1'b0; full = 1'b0; half = 1'b0; byte_ld = 1'b0; unsigned_ld = 1'b0;
    addr = $urandom;
  endtask

  // Issue a load, answer after lat REQ cycles, stall WB for hold cycles, record what happened.
  task automatic txn(input logic f, input logic h, input logic b, input logic u,
                     input logic [31:0] a, input logic [31:0] w, input int lat, input int hold);
    issue(f, h, b, u, a);
    obs_lat = 1; obs_addr = dm_addr; obs_stall_ok = 1'b1; obs_err = 1'b0; obs_hold_ok = 1'b1;
    for (int i = 1; i < lat; i++) begin
      if (stall !== 1'b1 || dm_req !== 1'b1) obs_stall_ok = 1'b0;
      if (adel || bus_err) obs_err = 1'b1;
      @(posedge clk); #1; obs_lat++;
    end
    if (stall !== 1'b1 || dm_req !== 1'b1) obs_stall_ok = 1'b0;
    dm_rvalid = 1'b1; dm_rdata = w;
    @(posedge clk); #1; obs_lat++;
    dm_rvalid = 1'b0; dm_rdata = $urandom;
    obs_valid = rd_valid; obs_data = rd_data;
    for (int i = 0; i < hold; i++) begin
      if (rd_valid !== 1'b1 || rd_data !== obs_data || stall !== 1'b1 || dm_req !== 1'b0)
        obs_hold_ok = 1'b0;
      if (adel || bus_err) obs_err = 1'b1;
      @(posedge clk); #1;
    end
    if (adel || bus_err) obs_err = 1'b1;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    obs_after = {rd_valid, stall, ld_ready};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++; if ({dm_req, rd_valid, stall, adel, bus_err} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl got %b exp 00000", {dm_req, rd_valid, stall, adel, bus_err}); end
    tests++; if ({rd_data, badvaddr, dm_addr} !== 94'b0) begin
      fails++; $display("FAIL reset_data got %h %h %h exp 0", rd_data, badvaddr, dm_addr); end
    tests++; if (ld_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ld_ready got %b exp 1", ld_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h1003, 32'h80FF1234, 1, 0);
    tests++; if (obs_data !== 32'hFFFFFF80) begin
      fails++; $display("FAIL lb_data got %h exp ffffff80", obs_data); end
    tests++; if (obs_lat !== 2 || obs_valid !== 1'b1) begin
      fails++; $display("FAIL lb_latency got %0d/%b exp 2/1", obs_lat, obs_valid); end
    tests++; if (obs_addr !== 30'h400) begin
      fails++; $display("FAIL lb_dm_addr got %h exp 400", obs_addr); end
    txn(1'b0, 1'b1, 1'b0, 1'b1, 32'h2002, 32'h8001ABCD, 2, 0);
    tests++; if (obs_data !== 32'h00008001) begin
      fails++; $display("FAIL lhu_data got %h exp 00008001", obs_data); end
    txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h2002, 32'h8001ABCD, 3, 0);
    tests++; if (obs_data !== 32'hFFFF8001) begin
      fails++; $display("FAIL lh_data got %h exp ffff8001", obs_data); end
  endtask

  task automatic test_backpressure();
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5004, 32'hDEADBEEF, 1, 3);
    tests++; if (obs_hold_ok !== 1'b1 || obs_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL hold_stable got %b/%h exp 1/deadbeef", obs_hold_ok, obs_data); end
    tests++; if (obs_after !== 3'b001) begin
      fails++; $display("FAIL hold_release got %b exp 001", obs_after); end
  endtask

  task automatic test_random();
    int sz, lat, hold, nb;
    logic f, h, b, u;
    logic [31:0] a, w, exp_d;
    for (int n = 0; n < 40; n++) begin
      sz = $urandom_range(0, 2); a = $urandom; w = $urandom; u = 1'($urandom);
      lat = $urandom_range(1, 6); hold = $urandom_range(0, 2);
      f = (sz == 2); h = (sz == 1) || (sz == 2 && 1'($urandom)); b = (sz == 0) || 1'($urandom);
      if (sz == 2) a[1:0] = 2'b00;
      if (sz == 1) a[0] = 1'b0;
      nb = (sz == 2) ? 4 : (sz == 1) ? 2 : 1;
      exp_d = model(nb, a[1:0], u, w);
      txn(f, h, b, u, a, w, lat, hold);
      tests++; if (obs_data !== exp_d || obs_valid !== 1'b1) begin
        fails++; $display("FAIL rand_data n=%0d sz=%0d a=%h got %h exp %h", n, sz, a, obs_data, exp_d); end
      tests++; if (obs_lat !== lat + 1) begin
        fails++; $display("FAIL rand_latency n=%0d got %0d exp %0d", n, obs_lat, lat + 1); end
      tests++; if (obs_addr !== a[31:2] || obs_stall_ok !== 1'b1 || obs_hold_ok !== 1'b1 || obs_err !== 1'b0) begin
        fails++; $display("FAIL rand_ctrl n=%0d addr %h exp %h stall_ok %b hold_ok %b err %b",
                          n, obs_addr, a[31:2], obs_stall_ok, obs_hold_ok, obs_err); end
      tests++; if (obs_after !== 3'b001) begin
        fails++; $display("FAIL rand_release n=%0d got %b exp 001", n, obs_after); end
    end
  endtask

  task automatic test_no_size();
    logic bad;
    bad = 1'b0;
    ld_valid = 1'b1; addr = 32'h0000_1001;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (dm_req !== 1'b0 || stall !== 1'b0 || ld_ready !== 1'b1 || adel !== 1'b0) bad = 1'b1;
    end
    ld_valid = 1'b0;
    tests++; if (bad !== 1'b0) begin
      fails++; $display("FAIL no_size_ignored got %b exp 0", bad); end
  endtask

  task automatic test_adel();
    logic [31:0] a;
    logic no_req;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h1002);
    tests++; if (adel !== 1'b1 || badvaddr !== 32'h1002) begin
      fails++; $display("FAIL adel_pulse got %b %h exp 1 00001002", adel, badvaddr); end
    tests++; if ({dm_req, stall, rd_valid, ld_ready, bus_err} !== 5'b0) begin
      fails++; $display("FAIL adel_ctrl got %b exp 00000", {dm_req, stall, rd_valid, ld_ready, bus_err}); end
    @(posedge clk); #1;
    tests++; if (adel !== 1'b0 || ld_ready !== 1'b1 || dm_req !== 1'b0) begin
      fails++; $display("FAIL adel_end got adel %b ld_ready %b dm_req %b exp 0 1 0", adel, ld_ready, dm_req); end
    a = $urandom; a[0] = 1'b1; no_req = 1'b1;
    issue(1'b0, 1'b1, 1'b1, 1'b0, a);
    if (dm_req !== 1'b0) no_req = 1'b0;
    tests++; if (adel !== 1'b1 || badvaddr !== a || no_req !== 1'b1) begin
      fails++; $display("FAIL adel_half got %b %h exp 1 %h", adel, badvaddr, a); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int cyc;
    logic seen, req_ok;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000);
    cyc = 1; seen = 1'b0; req_ok = 1'b1;
    while (!seen && cyc < 40) begin
      if (bus_err === 1'b1) seen = 1'b1;
      else begin
        if (dm_req !== 1'b1 || stall !== 1'b1) req_ok = 1'b0;
        @(posedge clk); #1; cyc++;
      end
    end
    tests++; if (seen !== 1'b1 || cyc !== 17) begin
      fails++; $display("FAIL timeout_cycle got seen=%b cyc=%0d exp 1 17", seen, cyc); end
    tests++; if (badvaddr !== 32'h3000 || req_ok !== 1'b1 || dm_req !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL timeout_state got bad=%h req_ok=%b dm_req=%b stall=%b exp 3000 1 0 0",
                        badvaddr, req_ok, dm_req, stall); end
    @(posedge clk); #1;
    tests++; if (bus_err !== 1'b0 || ld_ready !== 1'b1) begin
      fails++; $display("FAIL timeout_end got %b %b exp 0 1", bus_err, ld_ready); end
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000, 32'h12345678, 16, 0);
    tests++; if (obs_err !== 1'b0 || obs_data !== 32'h12345678 || obs_lat !== 17) begin
      fails++; $display("FAIL last_cycle_resp got err=%b data=%h lat=%0d exp 0 12345678 17",
                        obs_err, obs_data, obs_lat); end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h4000);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    tests++; if ({dm_req, rd_valid, stall, adel, bus_err, ld_ready} !== 6'b000001 || dm_addr !== 30'h0) begin
      fails++; $display("FAIL midreset_async got %b %h exp 000001 0",
                        {dm_req, rd_valid, stall, adel, bus_err, ld_ready}, dm_addr); end
    @(posedge clk); #1; rst_n = 1'b1;
    dm_rvalid = 1'b1; dm_rdata = 32'hCAFEF00D;
    @(posedge clk); #1; dm_rvalid = 1'b0;
    @(posedge clk); #1;
    tests++; if ({dm_req, rd_valid, stall, ld_ready} !== 4'b0001 || rd_data !== 32'h0) begin
      fails++; $display("FAIL stale_rvalid got %b %h exp 0001 0", {dm_req, rd_valid, stall, ld_ready}, rd_data); end
  endtask

  initial begin
    ld_valid = 1'b0; full = 1'b0; half = 1'b0; byte_ld = 1'b0; unsigned_ld = 1'b0;
    addr = '0; dm_rdata = '0; dm_rvalid = 1'b0; rd_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_no_size();
    test_adel();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
